// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port BRAM between NUM_REQ requesters.
// Define BRAM_ARB_BYPASS_EN for write-first forwarding on same-address read/write.
module bram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          bram_write,
    output logic [ADDR_WIDTH-1:0]         bram_wrt_addr,
    output logic [DATA_WIDTH-1:0]         bram_data,
    output logic                          bram_read,
    output logic [ADDR_WIDTH-1:0]         bram_read_addr,
    input  logic [DATA_WIDTH-1:0]         bram_o_data
);

    // Returns {found, id} of the first candidate at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                                  input logic [ID_WIDTH-1:0] ptr);
        logic [ID_WIDTH:0] res;
        int                idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (cand[idx]) res = {1'b1, idx[ID_WIDTH-1:0]};
        end
        return res;
    endfunction

    function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] id);
        if (int'(id) == NUM_REQ - 1) return '0;
        return id + 1'b1;
    endfunction

    logic [ID_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [NUM_REQ-1:0]    wr_cand, rd_cand;
    logic [ID_WIDTH:0]     wr_sel, rd_sel;
    logic                  wr_any, rd_any;
    logic [ID_WIDTH-1:0]   wr_id, rd_id;
    logic [NUM_REQ-1:0]    wr_gnt, rd_gnt;
    logic                  vld_p1;
    logic [ID_WIDTH-1:0]   id_p1;

    // Grants are suppressed while reset is held so req_ready reads 0 in reset.
    assign wr_cand = req_valid &  req_we & {NUM_REQ{RSTn}};
    assign rd_cand = req_valid & ~req_we & {NUM_REQ{RSTn}};

    always_comb begin
        wr_sel = rr_pick(wr_cand, wr_ptr);
        rd_sel = rr_pick(rd_cand, rd_ptr);
        wr_any = wr_sel[ID_WIDTH];
        rd_any = rd_sel[ID_WIDTH];
        wr_id  = wr_sel[ID_WIDTH-1:0];
        rd_id  = rd_sel[ID_WIDTH-1:0];
        wr_gnt = '0;
        rd_gnt = '0;
        if (wr_any) wr_gnt[wr_id] = 1'b1;
        if (rd_any) rd_gnt[rd_id] = 1'b1;
    end

    assign req_ready      = wr_gnt | rd_gnt;
    assign bram_write     = wr_any;
    assign bram_wrt_addr  = wr_any ? req_addr[int'(wr_id)*ADDR_WIDTH +: ADDR_WIDTH]  : '0;
    assign bram_data      = wr_any ? req_wdata[int'(wr_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bram_read      = rd_any;
    assign bram_read_addr = rd_any ? req_addr[int'(rd_id)*ADDR_WIDTH +: ADDR_WIDTH]  : '0;

    // Stage p0 -> p1: pointer advance and read response tagging
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld_p1 <= 1'b0;
            id_p1  <= '0;
        end else begin
            if (wr_any) wr_ptr <= next_ptr(wr_id);
            if (rd_any) begin
                rd_ptr <= next_ptr(rd_id);
                id_p1  <= rd_id;
            end
            vld_p1 <= rd_any;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_id    = id_p1;

`ifdef BRAM_ARB_BYPASS_EN
    logic                  coll_p0;
    logic                  coll_p1;
    logic [DATA_WIDTH-1:0] byp_data_p1;

    assign coll_p0 = wr_any & rd_any & (bram_wrt_addr == bram_read_addr);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) coll_p1 <= 1'b0;
        else       coll_p1 <= coll_p0;
    end

    always_ff @(posedge CLK) begin
        if (coll_p0) byp_data_p1 <= bram_data;
    end

    assign rsp_data = coll_p1 ? byp_data_p1 : bram_o_data;
`else
    assign rsp_data = bram_o_data;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a BRAM model, reference arbiter and response scoreboard.
module tb_bram_port_arbiter;

    logic         CLK;
    logic         RSTn;
    logic [3:0]   req_valid;
    logic [3:0]   req_we;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         bram_write;
    logic [7:0]   bram_wrt_addr;
    logic [31:0]  bram_data;
    logic         bram_read;
    logic [7:0]   bram_read_addr;
    logic [31:0]  bram_o_data;

    int errors = 0;
    int checks = 0;

    bram_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .bram_write(bram_write), .bram_wrt_addr(bram_wrt_addr), .bram_data(bram_data),
        .bram_read(bram_read), .bram_read_addr(bram_read_addr), .bram_o_data(bram_o_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // BRAM model: registered read-first, contents start all-ones
    logic [31:0] mem [256];
    logic [31:0] shadow [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = '1;
            shadow[i] = '1;
        end
        bram_o_data = '0;
    end
    always @(posedge CLK) begin
        if (bram_read)  bram_o_data <= mem[bram_read_addr];
        if (bram_write) mem[bram_wrt_addr] <= bram_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb_q[$];

    int m_wr_ptr = 0;
    int m_rd_ptr = 0;
    bit pend     = 1'b0;

    // Reference arbiter and scoreboard, evaluated mid-cycle
    always @(negedge CLK) begin
        int          wg, rg, idx;
        logic [3:0]  exp_ready;
        logic [31:0] exp_data;
        rsp_t        r;
        if (!RSTn) begin
            m_wr_ptr = 0;
            m_rd_ptr = 0;
            pend     = 1'b0;
            sb_q.delete();
            chk("rst_ready", req_ready, 4'b0000);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_bram_en", {bram_write, bram_read}, 2'b00);
        end else begin
            wg = -1;
            rg = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_wr_ptr + k) % 4;
                if (wg < 0 && req_valid[idx] && req_we[idx]) wg = idx;
                idx = (m_rd_ptr + k) % 4;
                if (rg < 0 && req_valid[idx] && !req_we[idx]) rg = idx;
            end
            exp_ready = 4'b0000;
            if (wg >= 0) exp_ready[wg] = 1'b1;
            if (rg >= 0) exp_ready[rg] = 1'b1;
            chk("req_ready", req_ready, exp_ready);
            chk("bram_write", bram_write, wg >= 0);
            chk("bram_wrt_addr", bram_wrt_addr, (wg >= 0) ? req_addr[wg*8 +: 8] : 8'h00);
            chk("bram_data", bram_data, (wg >= 0) ? req_wdata[wg*32 +: 32] : 32'h0);
            chk("bram_read", bram_read, rg >= 0);
            chk("bram_read_addr", bram_read_addr, (rg >= 0) ? req_addr[rg*8 +: 8] : 8'h00);
            chk("rsp_valid", rsp_valid, pend);
            if (pend) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1'b1, 1'b0);
                end else begin
                    r = sb_q.pop_front();
                    chk("rsp_id", rsp_id, r.id);
                    chk("rsp_data", rsp_data, r.data);
                end
            end
            pend = (rg >= 0);
            if (rg >= 0) begin
                exp_data = shadow[req_addr[rg*8 +: 8]];
`ifdef BRAM_ARB_BYPASS_EN
                if (wg >= 0 && req_addr[wg*8 +: 8] == req_addr[rg*8 +: 8])
                    exp_data = req_wdata[wg*32 +: 32];
`endif
                r.id   = 2'(rg);
                r.data = exp_data;
                sb_q.push_back(r);
                m_rd_ptr = (rg + 1) % 4;
            end
            if (wg >= 0) begin
                shadow[req_addr[wg*8 +: 8]] = req_wdata[wg*32 +: 32];
                m_wr_ptr = (wg + 1) % 4;
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [7:0] a, input logic [31:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*8 +: 8]    = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    initial begin
        int         n;
        logic [3:0] e;
        RSTn = 1'b0;
        clear_all();
        repeat (3) cyc();
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_id", rsp_id, 2'd0);
        chk("reset_ready", req_ready, 4'b0000);
        RSTn = 1'b1;
        cyc();

        // Single read of an unwritten location
        set_req(2, 1'b1, 1'b0, 8'h05, 32'h0);
        #1 chk("t1_ready", req_ready, 4'b0100);
        cyc();
        clear_all();
        #1;
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_id", rsp_id, 2'd2);
        chk("t1_rsp_data", rsp_data, 32'hFFFF_FFFF);

        // Wrap the read pointer back to 0, then four simultaneous readers
        set_req(3, 1'b1, 1'b0, 8'h07, 32'h0);
        cyc();
        clear_all();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 8'(i), 32'h0);
        for (int k = 0; k < 4; k++) begin
            e = 4'b0001 << k;
            #1 chk("t2_order", req_ready, e);
            cyc();
            set_req(k, 1'b0, 1'b0, 8'h00, 32'h0);
        end
        set_req(0, 1'b1, 1'b0, 8'h01, 32'h0);
        set_req(1, 1'b1, 1'b0, 8'h02, 32'h0);
        #1 chk("t2_ptr_wrapped", req_ready, 4'b0001);
        cyc();
        clear_all();
        cyc();

        // Concurrent write and read to different addresses, then read back
        set_req(1, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        set_req(3, 1'b1, 1'b0, 8'h20, 32'h0);
        #1;
        chk("t3_ready", req_ready, 4'b1010);
        chk("t3_bram_en", {bram_write, bram_read}, 2'b11);
        cyc();
        clear_all();
        set_req(0, 1'b1, 1'b0, 8'h10, 32'h0);
        #1 chk("t3_rd_ready", req_ready, 4'b0001);
        cyc();
        clear_all();
        #1 chk("t3_readback", rsp_data, 32'hDEAD_BEEF);

        // Same-address write and read in one cycle
        set_req(0, 1'b1, 1'b1, 8'h30, 32'h1234_5678);
        set_req(1, 1'b1, 1'b0, 8'h30, 32'h0);
        #1 chk("t4_ready", req_ready, 4'b0011);
        cyc();
        clear_all();
`ifdef BRAM_ARB_BYPASS_EN
        #1 chk("t4_collision", rsp_data, 32'h1234_5678);
`else
        #1 chk("t4_collision", rsp_data, 32'hFFFF_FFFF);
`endif
        cyc();

        // Fairness: requester 2 reads continuously, requester 0 comes and goes
        set_req(2, 1'b1, 1'b0, 8'h05, 32'h0);
        for (int round = 0; round < 4; round++) begin
            set_req(0, 1'b1, 1'b0, 8'h40 + 8'(round), 32'h0);
            #1;
            n = 0;
            while (req_ready[0] !== 1'b1 && n < 8) begin
                cyc();
                n++;
            end
            chk("fair_wait_lt4", n < 4, 1'b1);
            cyc();
            set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
            cyc();
        end
        clear_all();
        cyc();

        // Reset asserted right after a read grant
        set_req(1, 1'b1, 1'b0, 8'h05, 32'h0);
        #1 chk("t6_grant", req_ready, 4'b0010);
        cyc();
        RSTn = 1'b0;
        set_req(3, 1'b1, 1'b0, 8'h06, 32'h0);
        #1;
        chk("t6_rsp_dropped", rsp_valid, 1'b0);
        chk("t6_ready_in_rst", req_ready, 4'b0000);
        cyc();
        cyc();
        RSTn = 1'b1;
        #1;
        chk("t6_rsp_after_rel", rsp_valid, 1'b0);
        chk("t6_first_grant", req_ready, 4'b0010);
        cyc();
        clear_all();
        #1;
        chk("t6_rsp_valid", rsp_valid, 1'b1);
        chk("t6_rsp_id", rsp_id, 2'd1);

        repeat (3) cyc();
        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
